mips_lsu: RTL and testbench

Load/store unit for the MIPS MEM stage: the initiator side of the byte-addressed, little-endian data-memory port. Accepts one load or store request at a time from the pipeline and handles byte lanes, load sign/zero extension and read-modify-write for sub-word stores. The memory port always transfers a full 32-bit word at a 4-byte-aligned address.

---
 rtl/mips_lsu_pkg.sv | 19 +
 rtl/lsu_lane_mux.sv | 45 ++++
 rtl/mips_lsu.sv | 135 +++++++++++++
 tb/tb_mips_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: size encodings, FSM states, default address width.
// No logic; imported by mips_lsu and lsu_lane_mux.
// Backpressure: not applicable.
package mips_lsu_pkg;

    localparam int ADDR_W_DEF = 15;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_mux.sv
// Byte-lane steering for the LSU: load extract/extend and sub-word store merge into an old word.
// Latency: purely combinational.
// Backpressure: none.
module lsu_lane_mux
    import mips_lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rd_word[{offset, 3'b000} +: 8];
    assign half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_data = rd_word;
        st_word = rd_word;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sgn & byte_sel[7]}}, byte_sel};
                st_word[{offset, 3'b000} +: 8] = wr_data[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{sgn & half_sel[15]}}, half_sel};
                if (offset[1]) begin
                    st_word[31:16] = wr_data[15:0];
                end else begin
                    st_word[15:0] = wr_data[15:0];
                end
            end
            default: begin
                ld_data = rd_word;
                st_word = wr_data;
            end
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS MEM-stage load/store unit driving a word-wide, little-endian data-memory port (MIPS_LSU_MISALIGN_TRAP_EN: trap misaligned).
// Latency: load / word store respond 2 cycles after acceptance, sub-word store 3 (RMW), trapped access 1.
// Backpressure: one request in flight; req_ready only in IDLE, responses cannot be stalled.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata,
    output logic              mem_write
);

    lsu_state_t  state, state_nxt;
    logic        r_we, r_signed;
    logic [1:0]  r_size, r_off;
    logic [31:0] r_wdata;
    logic [1:0]  eff_size, eff_off;
    logic        trap, accept;
    logic [31:0] ld_data, st_word;

    // Strobes decode straight from state so an async reset drops them at once.
    assign req_ready  = (state == ST_IDLE);
    assign mem_read   = (state == ST_READ);
    assign mem_write  = (state == ST_WRITE);
    assign resp_valid = (state == ST_RESP);
    assign accept     = req_valid && req_ready;

    always_comb begin
        eff_size = (req_size == 2'b11) ? SZ_WORD : req_size;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
        trap = (req_size == 2'b11) ||
               ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        eff_off = req_addr[1:0];
`else
        trap = 1'b0;
        case (eff_size)
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            SZ_WORD: eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (trap)                                state_nxt = ST_RESP;
                    else if (req_we && eff_size == SZ_WORD) state_nxt = ST_WRITE;
                    else                                     state_nxt = ST_READ;
                end
            end
            ST_READ:  state_nxt = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    lsu_lane_mux u_lane_mux (
        .rd_word (mem_rdata),
        .wr_data (r_wdata),
        .offset  (r_off),
        .size    (r_size),
        .sgn     (r_signed),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= SZ_BYTE;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_we       <= req_we;
                r_signed   <= req_signed;
                r_size     <= eff_size;
                r_off      <= eff_off;
                r_wdata    <= req_wdata;
                resp_rdata <= '0;
                // Trapped requests never touch the port, so its address/data stay put.
                if (!trap) begin
                    mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                    if (req_we && eff_size == SZ_WORD) begin
                        mem_wdata <= req_wdata;
                    end
                end
            end
            if (state == ST_READ) begin
                if (r_we) mem_wdata  <= st_word;
                else      resp_rdata <= ld_data;
            end
        end
    end

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= trap;
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed scenarios plus random traffic against a byte-array memory model.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    localparam int AW = 15;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_signed;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_read, mem_write;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_lsu #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_write(mem_write)
    );

    // Data memory seen by the DUT (word array) and the reference view (byte array).
    logic [31:0]   words [0:8191];
    logic [7:0]    rb    [0:32767];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    assign mem_rdata = words[mem_addr[AW-1:2]];

    always @(posedge clk) begin
        if (mem_write)  words[mem_addr[AW-1:2]] <= mem_wdata;
        else if (pl_en) words[pl_addr[AW-1:2]]  <= pl_data;
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input int a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic int eff_addr(input int a, input logic [1:0] sz);
        return (sz == 2'd0) ? a : (sz == 2'd1) ? a - a % 2 : a - a % 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic sg);
        int e = eff_addr(a, sz);
        int n = nbytes(sz);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(rb[e + i]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] d);
        int e = eff_addr(a, sz);
        for (int i = 0; i < nbytes(sz); i++) rb[e + i] = d[8 * i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b = a - a % 4;
        return {rb[b + 3], rb[b + 2], rb[b + 1], rb[b]};
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        int b = a - a % 4;
        @(negedge clk);
        pl_en = 1'b1; pl_addr = AW'(b); pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 4; i++) rb[b + i] = d[8 * i +: 8];
    endtask

    task automatic set_req(input logic we, input logic [1:0] sz, input logic sg, input int a,
                           input logic [31:0] wd);
        req_we = we; req_size = sz; req_signed = sg; req_addr = AW'(a); req_wdata = wd;
    endtask

    // Issues one request from a negedge and observes it up to the response (lat=0 on timeout).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input int a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int nrd, output int nwr, output int nboth,
                          output int saddr, output logic [31:0] swd);
        bit acc = 1'b0;
        lat = 0; rd = '0; er = 1'b0; nrd = 0; nwr = 0; nboth = 0; saddr = 0; swd = '0;
        set_req(we, sz, sg, a, wd);
        req_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (req_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        if (!acc) begin req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        set_req(1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 32767)), $urandom);
        for (int j = 1; j <= 8; j++) begin
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; swd = mem_wdata; end
            if (mem_read && mem_write) nboth++;
            if (mem_read || mem_write) saddr = int'(mem_addr);
            if (resp_valid) begin lat = j; rd = resp_rdata; er = resp_err; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_chk++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
        n_chk++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
        n_chk++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_port: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word_rw;
        int lat, nrd, nwr, nb, sa; logic [31:0] rd, swd; logic er;
        do_req(1'b1, SZ_WORD, 1'b0, 'h40, 32'hDEAD_BEEF, lat, rd, er, nrd, nwr, nb, sa, swd);
        ref_store('h40, SZ_WORD, 32'hDEAD_BEEF);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_chk++; if (nwr !== 1 || nrd !== 0) begin n_fail++; $display("FAIL sw_strobes: got wr=%0d rd=%0d want 1 0", nwr, nrd); end
        n_chk++; if (sa !== 'h40 || swd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_port: got addr=%h data=%h want 0040 deadbeef", sa, swd); end
        do_req(1'b0, SZ_WORD, 1'b0, 'h40, 32'h0, lat, rd, er, nrd, nwr, nb, sa, swd);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_chk++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
        n_chk++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL lw_strobes: got rd=%0d wr=%0d want 1 0", nrd, nwr); end
    endtask

    task automatic test_subword_store;
        int lat, nrd, nwr, nb, sa; logic [31:0] rd, swd; logic er;
        preload('h40, 32'h1122_3344);
        do_req(1'b1, SZ_BYTE, 1'b0, 'h42, 32'h5566_77AA, lat, rd, er, nrd, nwr, nb, sa, swd);
        ref_store('h42, SZ_BYTE, 32'h5566_77AA);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d want 3", lat); end
        n_chk++; if (nrd !== 1 || nwr !== 1 || nb !== 0) begin n_fail++; $display("FAIL sb_strobes: got rd=%0d wr=%0d both=%0d want 1 1 0", nrd, nwr, nb); end
        n_chk++; if (swd !== 32'h11AA_3344 || sa !== 'h40) begin n_fail++; $display("FAIL sb_merge: got data=%h addr=%h want 11aa3344 0040", swd, sa); end
        n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sb_rdata: got %h want 0", rd); end
        do_req(1'b0, SZ_WORD, 1'b0, 'h40, 32'h0, lat, rd, er, nrd, nwr, nb, sa, swd);
        n_chk++; if (rd !== 32'h11AA_3344) begin n_fail++; $display("FAIL sb_readback: got %h want 11aa3344", rd); end
    endtask

    task automatic test_load_extend;
        int lat, nrd, nwr, nb, sa; logic [31:0] rd, swd; logic er;
        logic [1:0]  sz  [4] = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int          ad  [4] = '{'h40, 'h41, 'h42, 'h42};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000};
        preload('h40, 32'h8000_F0FF);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, er, nrd, nwr, nb, sa, swd);
            n_chk++; if (rd !== exp[i] || lat !== 2) begin n_fail++; $display("FAIL load_ext%0d: got %h lat=%0d want %h lat=2", i, rd, lat, exp[i]); end
        end
    endtask

    task automatic test_misalign;
        int lat, nrd, nwr, nb, sa; logic [31:0] rd, swd; logic er;
        logic [31:0] exp_rd = TRAP ? 32'h0 : 32'h8000_F0FF;
        do_req(1'b0, SZ_WORD, 1'b0, 'h41, 32'h0, lat, rd, er, nrd, nwr, nb, sa, swd);
        n_chk++; if (er !== TRAP) begin n_fail++; $display("FAIL mis_err: got %b want %b", er, TRAP); end
        n_chk++; if (lat !== (TRAP ? 1 : 2)) begin n_fail++; $display("FAIL mis_latency: got %0d want %0d", lat, TRAP ? 1 : 2); end
        n_chk++; if (nrd !== (TRAP ? 0 : 1) || nwr !== 0) begin n_fail++; $display("FAIL mis_strobes: got rd=%0d wr=%0d", nrd, nwr); end
        n_chk++; if (rd !== exp_rd) begin n_fail++; $display("FAIL mis_rdata: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_reset_mid;
        int nw = 0, nr = 0;
        preload('h44, 32'hCAFE_BABE);
        preload('h48, 32'h0102_0304);
        set_req(1'b1, SZ_HALF, 1'b0, 'h44, 32'h0000_1234);
        req_valid = 1'b1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_pre: got %b want 1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_chk++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmid_in_read: got %b want 1", mem_read); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (mem_read !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_read_drop: got rd=%b rv=%b want 0 0", mem_read, resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_post: got %b want 1", req_ready); end
        for (int i = 0; i < 5; i++) begin
            if (mem_write) nw++;
            if (resp_valid) nr++;
            @(negedge clk);
        end
        n_chk++; if (nw !== 0 || nr !== 0) begin n_fail++; $display("FAIL rmid_quiet: got wr=%0d resp=%0d want 0 0", nw, nr); end
        n_chk++; if (words['h44 >> 2] !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL rmid_mem: got %h want cafebabe", words['h44 >> 2]); end
        // Second case: reset lands inside the WRITE cycle of a word store.
        set_req(1'b1, SZ_WORD, 1'b0, 'h48, 32'hFFFF_0000);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        n_chk++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rwr_in_write: got %b want 1", mem_write); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rwr_async_drop: got %b want 0", mem_write); end
        @(negedge clk);
        rst_n = 1'b1;
        nw = 0; nr = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_write) nw++;
            if (resp_valid) nr++;
            @(negedge clk);
        end
        n_chk++; if (nw !== 0 || nr !== 0 || words['h48 >> 2] !== 32'h0102_0304) begin n_fail++; $display("FAIL rwr_quiet: got wr=%0d resp=%0d mem=%h want 0 0 01020304", nw, nr, words['h48 >> 2]); end
    endtask

    task automatic test_back_to_back;
        logic        bwe [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  bsz [3] = '{SZ_WORD, SZ_WORD, SZ_BYTE};
        int          bad [3] = '{'h100, 'h104, 'h109};
        logic [31:0] bwd [3];
        logic [31:0] exp [3];
        logic [31:0] got [3];
        int acc_cyc [3];
        int idx = 0, nresp = 0, bad_ready = 0;
        bwd[0] = 32'h0; bwd[1] = $urandom; bwd[2] = $urandom;
        exp[0] = ref_load(bad[0], bsz[0], 1'b0);
        ref_store(bad[1], bsz[1], bwd[1]); exp[1] = 32'h0;
        ref_store(bad[2], bsz[2], bwd[2]); exp[2] = 32'h0;
        got = '{32'hX, 32'hX, 32'hX};
        acc_cyc = '{0, 0, 0};
        set_req(bwe[0], bsz[0], 1'b0, bad[0], bwd[0]);
        req_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            if (req_ready && (mem_read || mem_write || resp_valid)) bad_ready++;
            if (resp_valid) begin got[nresp] = resp_rdata; nresp++; end
            if (req_ready && req_valid) begin
                acc_cyc[idx] = c;
                idx++;
                @(posedge clk);
                #1;
                if (idx < 3) set_req(bwe[idx], bsz[idx], 1'b0, bad[idx], bwd[idx]);
                else req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_chk++; if (idx !== 3 || nresp !== 3) begin n_fail++; $display("FAIL b2b_counts: got acc=%0d resp=%0d want 3 3", idx, nresp); end
        n_chk++; if (bad_ready !== 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d want 0", bad_ready); end
        n_chk++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d %0d want 3 3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_resp%0d: got %h want %h", i, got[i], exp[i]); end
        end
        repeat (3) @(negedge clk);
        n_chk++; if (words['h104 >> 2] !== ref_word('h104) || words['h108 >> 2] !== ref_word('h108)) begin n_fail++; $display("FAIL b2b_mem: got %h %h want %h %h", words['h104 >> 2], words['h108 >> 2], ref_word('h104), ref_word('h108)); end
    endtask

    task automatic test_random;
        int lat, nrd, nwr, nb, sa; logic [31:0] rd, swd; logic er;
        for (int k = 0; k < 60; k++) begin
            logic        we = 1'($urandom);
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic        sg = 1'($urandom);
            int          a  = 'h100 + int'($urandom_range(0, 31));
            logic [31:0] wd = $urandom;
            bit   trapped = TRAP && is_mis(a, sz);
            int   e_lat = trapped ? 1 : (!we ? 2 : (nbytes(sz) == 4 ? 2 : 3));
            int   e_nrd = trapped ? 0 : (!we ? 1 : (nbytes(sz) == 4 ? 0 : 1));
            int   e_nwr = (!trapped && we) ? 1 : 0;
            logic [31:0] e_rd = (!trapped && !we) ? ref_load(a, sz, sg) : 32'h0;
            int   e_sa = (e_nrd + e_nwr > 0) ? eff_addr(a, sz) - eff_addr(a, sz) % 4 : 0;
            do_req(we, sz, sg, a, wd, lat, rd, er, nrd, nwr, nb, sa, swd);
            if (!trapped && we) ref_store(a, sz, wd);
            n_chk++; if (lat !== e_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, e_lat); end
            n_chk++; if (er !== trapped) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", k, er, trapped); end
            n_chk++; if (rd !== e_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h (a=%h sz=%0d sg=%b)", k, rd, e_rd, a, sz, sg); end
            n_chk++; if (nrd !== e_nrd || nwr !== e_nwr || nb !== 0) begin n_fail++; $display("FAIL rnd%0d_strobes: got rd=%0d wr=%0d both=%0d want %0d %0d 0", k, nrd, nwr, nb, e_nrd, e_nwr); end
            n_chk++; if (sa !== e_sa) begin n_fail++; $display("FAIL rnd%0d_addr: got %h want %h", k, sa, e_sa); end
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (words[('h100 >> 2) + i] !== ref_word('h100 + 4 * i)) begin n_fail++; $display("FAIL rnd_mem%0d: got %h want %h", i, words[('h100 >> 2) + i], ref_word('h100 + 4 * i)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        set_req(1'b0, SZ_BYTE, 1'b0, 0, 32'h0);
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 8; i++) preload('h40 + 4 * i, $urandom);
        for (int i = 0; i < 8; i++) preload('h100 + 4 * i, $urandom);
        test_reset;
        test_word_rw;
        test_subword_store;
        test_load_extend;
        test_misalign;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
